// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Round-robin arbiter that shares one WIDTH-bit output channel between four
// requesters. It drives the select of a 4:1 mux (sel=0 picks requester 0) and
// holds each grant until the sink accepts the beat (out_valid & out_ready).
// On every accepted beat the last winner drops to lowest priority and a new
// winner is picked on the same edge, so continuous traffic has no bubbles.
//
// Compile-time option:
//   RR_ARB_LOCK_EN  - when defined, a grant is held across a multi-beat packet
//                     until a beat with in_last[sel]=1 is accepted. When not
//                     defined, in_last is ignored and every beat re-arbitrates.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req[3:0]   request per requester, held high until acked
//   in_data    requester i data at [i*WIDTH +: WIDTH]
//   in_last    last-beat flag per requester (lock build only)
//   out_valid  output beat valid
//   out_ready  sink accepts beat
//   out_data   data of the granted requester (combinational mux)
//   gnt[3:0]   one-hot grant, registered
//   sel[1:0]   binary index of the granted requester, registered
//   ack[3:0]   one-cycle acceptance pulse to the granted requester
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [3:0]         gnt,
  output logic [1:0]         sel,
  output logic [3:0]         ack
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_next;
  logic [1:0] r_sel;
  logic [1:0] w_sel_next;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_next;

  logic       w_xfer;
  logic       w_hold_pkt;
  logic [1:0] w_arb_ptr;
  logic [3:0] w_rot;
  logic [1:0] w_offset;
  logic       w_found;
  logic [1:0] w_winner;

  assign out_valid = (r_state == GRANT);
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign out_data  = in_data[r_sel*WIDTH +: WIDTH];

  // Reset in the same cycle suppresses the acceptance pulse: the beat is
  // discarded rather than delivered.
  assign w_xfer = out_valid & out_ready & ~rst;
  assign ack    = w_xfer ? r_gnt : 4'b0000;

`ifdef RR_ARB_LOCK_EN
  // Mid-packet beat: keep the grant on the same requester.
  assign w_hold_pkt = ~in_last[r_sel];
`else
  assign w_hold_pkt = 1'b0;
  logic w_unused_last;
  assign w_unused_last = &in_last;
`endif

  // When a beat is accepted in GRANT, the current winner becomes the new
  // priority pointer on this very edge, so arbitrate relative to r_sel.
  assign w_arb_ptr = (r_state == GRANT) ? r_sel : r_ptr;

  // Rotate requests so w_rot[0] is the highest-priority candidate (ptr+1)
  // and w_rot[3] the lowest (ptr itself).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] w_idx;
      assign w_idx     = w_arb_ptr + 2'(gi + 1);
      assign w_rot[gi] = req[w_idx];
    end
  endgenerate

  always_comb begin
    w_offset = 2'd3;
    if (w_rot[0])      w_offset = 2'd0;
    else if (w_rot[1]) w_offset = 2'd1;
    else if (w_rot[2]) w_offset = 2'd2;
  end

  assign w_found  = |w_rot;
  assign w_winner = w_arb_ptr + 2'd1 + w_offset;

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_sel_next   = r_sel;
    w_ptr_next   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next = GRANT;
          w_gnt_next   = 4'b0001 << w_winner;
          w_sel_next   = w_winner;
        end
      end
      GRANT: begin
        if (w_xfer && !w_hold_pkt) begin
          w_ptr_next = r_sel;
          if (w_found) begin
            w_gnt_next = 4'b0001 << w_winner;
            w_sel_next = w_winner;
          end else begin
            w_state_next = IDLE;
            w_gnt_next   = 4'b0000;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd3;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_sel   <= w_sel_next;
      r_ptr   <= w_ptr_next;
    end
  end

endmodule
